// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: state enum, opcode constants,
// datapath mux/ALU-control encodings and the per-state Moore output decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD,
    MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, TRAP
  } ctrlStateT;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IFUNCT = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       iord;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       pcSrc;
  } ctrlOutT;

  // Input-independent strobes for each state; handshake-gated strobes are added by the top.
  function automatic ctrlOutT decodeState(input ctrlStateT s);
    ctrlOutT o;
    o = '0;
    case (s)
      FETCH: begin
        o.memRead = 1'b1;
        o.aluSrcA = SRC_A_PC;
        o.aluSrcB = SRC_B_FOUR;
        o.aluOp   = ALU_OP_ADD;
      end
      DECODE: begin
        o.aluSrcA = SRC_A_OLDPC;
        o.aluSrcB = SRC_B_IMM;
        o.aluOp   = ALU_OP_ADD;
      end
      EXEC_R: begin
        o.aluSrcA = SRC_A_RS1;
        o.aluSrcB = SRC_B_RS2;
        o.aluOp   = ALU_OP_RFUNCT;
      end
      EXEC_I: begin
        o.aluSrcA = SRC_A_RS1;
        o.aluSrcB = SRC_B_IMM;
        o.aluOp   = ALU_OP_IFUNCT;
      end
      MEM_ADDR: begin
        o.aluSrcA = SRC_A_RS1;
        o.aluSrcB = SRC_B_IMM;
        o.aluOp   = ALU_OP_ADD;
      end
      MEM_RD: begin
        o.memRead = 1'b1;
        o.iord    = 1'b1;
      end
      MEM_WR: begin
        o.memWrite = 1'b1;
        o.iord     = 1'b1;
      end
      WB_ALU: o.regWrite = 1'b1;
      WB_MEM: begin
        o.regWrite = 1'b1;
        o.memToReg = 1'b1;
      end
      BRANCH: begin
        o.aluSrcA = SRC_A_RS1;
        o.aluSrcB = SRC_B_RS2;
        o.aluOp   = ALU_OP_SUB;
        o.pcSrc   = 1'b1;
      end
      JAL: begin
        o.aluSrcA  = SRC_A_OLDPC;
        o.aluSrcB  = SRC_B_FOUR;
        o.regWrite = 1'b1;
        o.pcSrc    = 1'b1;
        o.pcWrite  = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on a memory handshake and flags a timeout
// once the limit is reached without ready.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ready,
  output logic timeout
);

  logic [7:0] waitCount;

  // Leaving a wait state always clears the count, so every entry to a wait state starts at 0.
  always_ff @(posedge clk) begin
    if (rst || !waiting || ready) begin
      waitCount <= 8'd0;
    end else if (waitCount != 8'hFF) begin
      waitCount <= waitCount + 8'd1;
    end
  end

  assign timeout = waiting && !ready && (waitCount == 8'(LIMIT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM with illegal-opcode and memory-timeout traps.
// Optional retire counter enabled by defining CTRL_RETIRE_CNT_EN.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int TIMEOUT_CYC = 15
`ifdef CTRL_RETIRE_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic                pc_write,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                pc_src,
  output logic                trap,
  output logic                illegal_instr,
  output logic                mem_timeout
`ifdef CTRL_RETIRE_CNT_EN
  , output logic [CNT_W-1:0]  retire_count
`endif
);

  ctrlStateT  state, nextState;
  ctrlOutT    outQ;
  logic       trapQ, illegalQ, timeoutQ;
  logic       waiting, waitTimeout;
  logic [6:0] op;

  assign op      = 7'(opcode);
  assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

  mem_wait_timer #(.LIMIT(TIMEOUT_CYC)) uWaitTimer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .ready   (mem_ready),
    .timeout (waitTimeout)
  );

  // Next-state selection; a ready on the timeout cycle still completes the access.
  always_comb begin
    nextState = state;
    case (state)
      FETCH:    if (mem_ready) nextState = DECODE; else if (waitTimeout) nextState = TRAP;
      DECODE: begin
        case (op)
          OP_R:               nextState = EXEC_R;
          OP_I:               nextState = EXEC_I;
          OP_LOAD, OP_STORE:  nextState = MEM_ADDR;
          OP_BRANCH:          nextState = BRANCH;
          OP_JAL:             nextState = JAL;
          default:            nextState = TRAP;
        endcase
      end
      EXEC_R, EXEC_I:         nextState = WB_ALU;
      MEM_ADDR:               nextState = (op == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) nextState = WB_MEM; else if (waitTimeout) nextState = TRAP;
      MEM_WR:   if (mem_ready) nextState = FETCH;  else if (waitTimeout) nextState = TRAP;
      WB_ALU, WB_MEM, BRANCH, JAL: nextState = FETCH;
      TRAP:                   nextState = TRAP;
      default:                nextState = FETCH;
    endcase
  end

  // Strobes are registered from the decode of the state being entered, so they change
  // exactly with the state register; trap causes are sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      outQ     <= decodeState(FETCH);
      trapQ    <= 1'b0;
      illegalQ <= 1'b0;
      timeoutQ <= 1'b0;
`ifdef CTRL_RETIRE_CNT_EN
      retire_count <= '0;
`endif
    end else begin
      state <= nextState;
      outQ  <= decodeState(nextState);
      if (nextState == TRAP) trapQ <= 1'b1;
      if (state == DECODE && nextState == TRAP) illegalQ <= 1'b1;
      if (waitTimeout) timeoutQ <= 1'b1;
`ifdef CTRL_RETIRE_CNT_EN
      if (nextState == FETCH &&
          (state inside {WB_ALU, WB_MEM, MEM_WR, BRANCH, JAL})) begin
        retire_count <= retire_count + 1'b1;
      end
`endif
    end
  end

  // The PC/IR load strobes follow the memory handshake and branch outcome directly.
  assign pc_write      = outQ.pcWrite
                       | ((state == FETCH)  && mem_ready)
                       | ((state == BRANCH) && branch_taken);
  assign ir_write      = (state == FETCH) && mem_ready;
  assign iord          = outQ.iord;
  assign mem_read      = outQ.memRead;
  assign mem_write     = outQ.memWrite;
  assign reg_write     = outQ.regWrite;
  assign mem_to_reg    = outQ.memToReg;
  assign alu_src_a     = outQ.aluSrcA;
  assign alu_src_b     = outQ.aluSrcB;
  assign alu_op        = ALUOP_W'(outQ.aluOp);
  assign pc_src        = outQ.pcSrc;
  assign trap          = trapQ;
  assign illegal_instr = illegalQ;
  assign mem_timeout   = timeoutQ;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: a per-instruction phase plan is built
// from the instruction class and wait counts, then every cycle is compared against it.
module tb_multicycle_control_fsm;

  localparam int TIMEOUT_CYC = 15;
`ifdef CTRL_RETIRE_CNT_EN
  localparam int CNT_W = 4;
`endif

  localparam logic [6:0] TB_OP_R      = 7'b0110011;
  localparam logic [6:0] TB_OP_I      = 7'b0010011;
  localparam logic [6:0] TB_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] TB_OP_STORE  = 7'b0100011;
  localparam logic [6:0] TB_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] TB_OP_JAL    = 7'b1101111;

  logic clk = 1'b0;
  logic rst, mem_ready, branch_taken;
  logic [6:0] opcode;
  logic pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic trap, illegal_instr, mem_timeout;
`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_count;
`endif

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .OPCODE_W    (7),
    .ALUOP_W     (2),
    .TIMEOUT_CYC (TIMEOUT_CYC)
`ifdef CTRL_RETIRE_CNT_EN
    , .CNT_W     (CNT_W)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .trap          (trap),
    .illegal_instr (illegal_instr),
    .mem_timeout   (mem_timeout)
`ifdef CTRL_RETIRE_CNT_EN
    , .retire_count (retire_count)
`endif
  );

  typedef enum {P_FETCH, P_DECODE, P_EXEC_R, P_EXEC_I, P_MEM_ADDR, P_MEM_RD,
                P_MEM_WR, P_WB_ALU, P_WB_MEM, P_BRANCH, P_JAL, P_TRAP} phaseT;

  typedef struct {
    phaseT ph;
    bit    rdyFixed;
    bit    rdy;
    bit    tkn;
    bit    retires;
    int    cause;
  } stepT;

  stepT plan[$];
  int   checks = 0;
  int   failures = 0;
  int   expRetire = 0;
  logic [6:0] legalOps [6];

  function automatic stepT mkStep(phaseT ph, bit rdyFixed, bit rdy, bit tkn, bit retires, int cause);
    stepT s;
    s.ph = ph; s.rdyFixed = rdyFixed; s.rdy = rdy; s.tkn = tkn; s.retires = retires; s.cause = cause;
    return s;
  endfunction

  // Expected control word for one cycle of a phase, given the inputs driven in that cycle.
  function automatic logic [16:0] expVec(stepT s, logic rdy, logic tkn);
    logic pcW, irW, io, mRd, mWr, rW, m2r, pcS, tr, il, to;
    logic [1:0] a, b, aop;
    {pcW, irW, io, mRd, mWr, rW, m2r, pcS, tr, il, to} = '0;
    a = 2'b00; b = 2'b00; aop = 2'b00;
    case (s.ph)
      P_FETCH:    begin mRd = 1; b = 2'b10; pcW = rdy; irW = rdy; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; end
      P_EXEC_R:   begin a = 2'b10; b = 2'b00; aop = 2'b10; end
      P_EXEC_I:   begin a = 2'b10; b = 2'b01; aop = 2'b11; end
      P_MEM_ADDR: begin a = 2'b10; b = 2'b01; end
      P_MEM_RD:   begin io = 1; mRd = 1; end
      P_MEM_WR:   begin io = 1; mWr = 1; end
      P_WB_ALU:   rW = 1;
      P_WB_MEM:   begin rW = 1; m2r = 1; end
      P_BRANCH:   begin a = 2'b10; b = 2'b00; aop = 2'b01; pcS = 1; pcW = tkn; end
      P_JAL:      begin a = 2'b01; b = 2'b10; rW = 1; pcS = 1; pcW = 1; end
      P_TRAP:     begin tr = 1; il = (s.cause == 1); to = (s.cause == 2); end
      default:    ;
    endcase
    return {pcW, irW, io, mRd, mWr, rW, m2r, a, b, aop, pcS, tr, il, to};
  endfunction

  function automatic logic [16:0] obsVec();
    return {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, pc_src, trap, illegal_instr, mem_timeout};
  endfunction

  task automatic buildPlan(input logic [6:0] op, input int fetchWait, input int memWait,
                           input bit tkn, input int trapHold);
    phaseT wp;
    for (int i = 0; i < fetchWait; i++) plan.push_back(mkStep(P_FETCH, 1, 0, 0, 0, 0));
    plan.push_back(mkStep(P_FETCH, 1, 1, 0, 0, 0));
    plan.push_back(mkStep(P_DECODE, 0, 0, 0, 0, 0));
    case (op)
      TB_OP_R: begin
        plan.push_back(mkStep(P_EXEC_R, 0, 0, 0, 0, 0));
        plan.push_back(mkStep(P_WB_ALU, 0, 0, 0, 1, 0));
      end
      TB_OP_I: begin
        plan.push_back(mkStep(P_EXEC_I, 0, 0, 0, 0, 0));
        plan.push_back(mkStep(P_WB_ALU, 0, 0, 0, 1, 0));
      end
      TB_OP_LOAD, TB_OP_STORE: begin
        plan.push_back(mkStep(P_MEM_ADDR, 0, 0, 0, 0, 0));
        wp = (op == TB_OP_LOAD) ? P_MEM_RD : P_MEM_WR;
        if (memWait > TIMEOUT_CYC) begin
          for (int i = 0; i <= TIMEOUT_CYC; i++) plan.push_back(mkStep(wp, 1, 0, 0, 0, 0));
          for (int i = 0; i < trapHold; i++) plan.push_back(mkStep(P_TRAP, 0, 0, 0, 0, 2));
        end else begin
          for (int i = 0; i < memWait; i++) plan.push_back(mkStep(wp, 1, 0, 0, 0, 0));
          plan.push_back(mkStep(wp, 1, 1, 0, op == TB_OP_STORE, 0));
          if (op == TB_OP_LOAD) plan.push_back(mkStep(P_WB_MEM, 0, 0, 0, 1, 0));
        end
      end
      TB_OP_BRANCH: plan.push_back(mkStep(P_BRANCH, 0, 0, tkn, 1, 0));
      TB_OP_JAL:    plan.push_back(mkStep(P_JAL, 0, 0, 0, 1, 0));
      default: for (int i = 0; i < trapHold; i++) plan.push_back(mkStep(P_TRAP, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic checkOutput(input stepT s, input string tag);
    logic [16:0] e;
    e = expVec(s, mem_ready, branch_taken);
    checks++;
    assert (obsVec() === e) else begin
      failures++;
      $error("FAIL %s/%s: observed %b expected %b", tag, s.ph.name(), obsVec(), e);
    end
`ifdef CTRL_RETIRE_CNT_EN
    checks++;
    assert (retire_count === CNT_W'(expRetire)) else begin
      failures++;
      $error("FAIL %s/retire: observed %0d expected %0d", tag, retire_count, CNT_W'(expRetire));
    end
`endif
  endtask

  // Plays the plan one cycle per negedge; resetAt >= 0 asserts rst during that step and drops the rest.
  task automatic applyStimulus(input string tag, input int resetAt);
    stepT s;
    int idx;
    idx = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      mem_ready    = s.rdyFixed ? s.rdy : 1'($urandom_range(0, 1));
      branch_taken = (s.ph == P_BRANCH) ? s.tkn : 1'($urandom_range(0, 1));
      if (idx == resetAt) rst = 1'b1;
      #1;
      checkOutput(s, tag);
      if (s.retires && idx != resetAt) expRetire++;
      @(negedge clk);
      if (idx == resetAt) begin
        rst = 1'b0;
        expRetire = 0;
        plan.delete();
      end
      idx++;
    end
  endtask

  task automatic runInstr(input logic [6:0] op, input int fetchWait, input int memWait,
                          input bit tkn, input int trapHold, input string tag, input int resetAt);
    opcode = op;
    buildPlan(op, fetchWait, memWait, tkn, trapHold);
    applyStimulus(tag, resetAt);
  endtask

  task automatic doReset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expRetire = 0;
  endtask

  initial begin
    legalOps = '{TB_OP_R, TB_OP_I, TB_OP_LOAD, TB_OP_STORE, TB_OP_BRANCH, TB_OP_JAL};
    $display("[TB] starting multicycle_control_fsm bench");
    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = TB_OP_R;
    @(negedge clk);
    doReset();

    runInstr(TB_OP_R, 1, 0, 0, 0, "rtype", -1);
    runInstr(TB_OP_R, 0, 0, 0, 0, "rtypeZeroWait", -1);
    runInstr(TB_OP_LOAD, 0, 3, 0, 0, "loadWait3", -1);
    runInstr(TB_OP_BRANCH, 0, 0, 1, 0, "branchTaken", -1);
    runInstr(TB_OP_BRANCH, 0, 0, 0, 0, "branchNotTaken", -1);
    runInstr(TB_OP_I, 2, 0, 0, 0, "itype", -1);
    runInstr(TB_OP_STORE, 0, 0, 0, 0, "storeZeroWait", -1);
    runInstr(TB_OP_JAL, 0, 0, 0, 0, "jal", -1);

    runInstr(7'b1111111, 0, 0, 0, 20, "illegal", -1);
    doReset();
    runInstr(TB_OP_R, 0, 0, 0, 0, "postIllegal", -1);

    runInstr(TB_OP_STORE, 0, 100, 0, 4, "storeTimeout", -1);
    doReset();
    runInstr(TB_OP_STORE, 0, TIMEOUT_CYC, 0, 0, "storeReadyAtLimit", -1);
    runInstr(TB_OP_LOAD, 0, 100, 0, 3, "loadTimeout", -1);
    doReset();
    runInstr(TB_OP_LOAD, 0, TIMEOUT_CYC, 0, 0, "loadReadyAtLimit", -1);

    runInstr(TB_OP_STORE, 0, 5, 0, 0, "resetMidWrite", 4);
    runInstr(TB_OP_JAL, 0, 0, 0, 0, "postWriteReset", -1);

`ifdef CTRL_RETIRE_CNT_EN
    doReset();
    for (int i = 0; i < 17; i++) runInstr(TB_OP_JAL, 0, 0, 0, 0, "jalWrap", -1);
    #1;
    checks++;
    assert (retire_count === 4'd1) else begin
      failures++;
      $error("FAIL retireWrap: observed %0d expected 1", retire_count);
    end
    runInstr(TB_OP_R, 0, 0, 0, 0, "resetMidExec", 2);
    runInstr(TB_OP_R, 0, 0, 0, 0, "postExecReset", -1);
`else
    runInstr(TB_OP_R, 0, 0, 0, 0, "resetMidExec", 2);
    runInstr(TB_OP_R, 0, 0, 0, 0, "postExecReset", -1);
`endif

    for (int i = 0; i < 40; i++) begin
      runInstr(legalOps[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 6),
               1'($urandom_range(0, 1)), 0, "random", -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
